reg_file_mp: RTL
================

// Module: reg_file_mp
// PURPOSE
//  Parametrised multi-port register file for the pipelined ARM datapath: NUM_RD async read
//  ports, two write ports (A = writeback result, B = base-register writeback), optional
//  same-cycle write->read bypass, R15 read-as-PC, and a per-register busy scoreboard that
//  flags read-after-write hazards to the decode-stage stall logic.
// PARAMETERS
//  DATA_W   32  register width in bits
//  ADDR_W   4   address width; depth = 2**ADDR_W registers
//  NUM_RD   3   number of read ports (Rn, Rm, Rs/Rd-for-store)
//  BYPASS   1   1: read returns same-cycle write data; 0: new value visible next cycle
//  PC_EN    1   1: register PC_IDX is architectural PC (reads = pc_plus8, writes dropped)
//  PC_IDX   15  index of PC register
// PORTS
//  clk        in   1               rising-edge clock
//  rst_n      in   1               asynchronous, active-low reset
//  wr_en_a    in   1               write port A enable (priority port)
//  wr_addr_a  in   ADDR_W          write port A address
//  wr_data_a  in   DATA_W          write port A data
//  wr_en_b    in   1               write port B enable
//  wr_addr_b  in   ADDR_W          write port B address
//  wr_data_b  in   DATA_W          write port B data
//  rd_addr    in   NUM_RD*ADDR_W   packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//  rd_data    out  NUM_RD*DATA_W   packed read data, port i at [i*DATA_W +: DATA_W]
//  pc_plus8   in   DATA_W          value returned for reads of PC_IDX when PC_EN=1
//  iss_en     in   1               instruction issued that will later write iss_addr
//  iss_addr   in   ADDR_W          destination register of issued instruction
//  rd_hazard  out  NUM_RD          port i reads a busy register not covered by bypass
//  stall      out  1               OR of rd_hazard
//  busy       out  2**ADDR_W       scoreboard bit per register
// BEHAVIOUR
//  - Reset (rst_n=0, async): all registers <= 0, busy <= 0. rd_data therefore reads 0
//    (except PC_IDX -> pc_plus8), rd_hazard=0, stall=0. Reset mid-write: write lost.
//  - Writes commit on posedge clk. Both ports enabled, same address: port A wins, B dropped.
//    PC_EN=1 and write address = PC_IDX: write ignored (neither reg nor busy changed by B).
//  - Reads combinational, zero latency. Priority per port i: PC_IDX match (PC_EN=1) ->
//    pc_plus8; else BYPASS=1 and wr_en_a & addr match -> wr_data_a; else BYPASS=1 and
//    wr_en_b & addr match -> wr_data_b; else stored value.
//  - Scoreboard, updated on posedge: iss_en sets busy[iss_addr]; wr_en_a clears
//    busy[wr_addr_a]. Same address set+clear in one cycle: set wins (newer producer).
//    Port B never touches busy. PC_IDX busy bit always 0 when PC_EN=1.
//  - rd_hazard[i] = busy[rd_addr_i] & ~(BYPASS & wr_en_a & wr_addr_a==rd_addr_i);
//    forced 0 for PC_IDX when PC_EN=1. stall = |rd_hazard. Combinational, same cycle.
//  - Width: no truncation/extension; all data paths exactly DATA_W.
// TESTING
//  1. Reset: write 0xDEADBEEF to R3, pulse rst_n low mid-cycle -> R3 reads 0 immediately,
//     busy=0, stall=0.
//  2. Bypass: BYPASS=1, wr_en_a, addr 2, data 0xAAAAAAAA, rd_addr port0=2 same cycle ->
//     rd_data0=0xAAAAAAAA before edge; BYPASS=0 -> old value, 0xAAAAAAAA after edge.
//  3. Dual write collision: A and B both to R5 (A=0x11111111, B=0x22222222) -> R5 reads
//     0x11111111 next cycle; B alone to R6=0x33333333 -> R6 reads 0x33333333.
//  4. PC: pc_plus8=0x00000108, read R15 on all ports -> 0x00000108; write R15=0x5 ->
//     still 0x00000108; iss_en to R15 -> no hazard.
//  5. Scoreboard: iss_en R4; next cycle read R4 -> rd_hazard=1, stall=1; wr_en_a R4
//     0x44 that cycle -> hazard 0 (bypass), busy[4]=0 after edge; iss_en+wr_en_a both R4
//     same cycle -> busy[4]=1 after edge.
//  6. Multi-port: NUM_RD=3, read R1/R2/R4 simultaneously after writes 0x1/0x2/0x4 ->
//     each port returns its own value; randomised ref-model run, 1000 cycles, no mismatch.

Source files
------------

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with write bypass, read-as-PC and busy scoreboard
module reg_file_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int NUM_RD = 3,
    parameter int BYPASS = 1,
    parameter int PC_EN  = 1,
    parameter int PC_IDX = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en_a,
    input  logic [ADDR_W-1:0]        wr_addr_a,
    input  logic [DATA_W-1:0]        wr_data_a,
    input  logic                     wr_en_b,
    input  logic [ADDR_W-1:0]        wr_addr_b,
    input  logic [DATA_W-1:0]        wr_data_b,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic [DATA_W-1:0]        pc_plus8,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic [NUM_RD-1:0]        rd_hazard,
    output logic                     stall,
    output logic [2**ADDR_W-1:0]     busy
);
    localparam int              DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);
    localparam bit              PC_ON = PC_EN != 0;
    localparam bit              BYP   = BYPASS != 0;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic              we_a, we_b;

    // Write commit: PC writes dropped, port A beats port B on an address collision
    always_comb begin
        we_a   = wr_en_a && !(PC_ON && wr_addr_a == PC_A);
        we_b   = wr_en_b && !(PC_ON && wr_addr_b == PC_A) && !(wr_en_a && wr_addr_a == wr_addr_b);
        regs_d = regs_q;
        if (we_b) regs_d[wr_addr_b] = wr_data_b;
        if (we_a) regs_d[wr_addr_a] = wr_data_a;
    end

    // Scoreboard: writeback clears, issue sets afterwards so a newer producer wins
    always_comb begin
        busy_d = busy_q;
        if (wr_en_a) busy_d[wr_addr_a] = 1'b0;
        if (iss_en) busy_d[iss_addr] = 1'b1;
        if (PC_ON) busy_d[PC_A] = 1'b0;
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) regs_q[r] <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              pc_hit, hit_a, hit_b;
        assign ra     = rd_addr[g*ADDR_W +: ADDR_W];
        assign pc_hit = PC_ON && ra == PC_A;
        assign hit_a  = BYP && wr_en_a && wr_addr_a == ra;
        assign hit_b  = BYP && wr_en_b && wr_addr_b == ra;
        assign rd_data[g*DATA_W +: DATA_W] = pc_hit ? pc_plus8 :
                                             hit_a  ? wr_data_a :
                                             hit_b  ? wr_data_b : regs_q[ra];
        assign rd_hazard[g] = !pc_hit && busy_q[ra] && !hit_a;
    end

    assign stall = |rd_hazard;
    assign busy  = busy_q;
endmodule
